// File: rtl/bp_table_if.sv
// Lookup/update handshake bundle between the fetch/resolve stages and the
// shared branch-prediction table controller.
interface bp_table_if #(
  parameter int IDX_W = 4
);
  logic [1:0]       req_valid;
  logic [IDX_W-1:0] req_idx0;
  logic [IDX_W-1:0] req_idx1;
  logic [1:0]       req_ready;
  logic [1:0]       resp_valid;
  logic             resp_pred;
  logic             upd_valid;
  logic [IDX_W-1:0] upd_idx;
  logic             upd_taken;
  logic             upd_ready;
  logic             init_done;

  modport master (
    output req_valid, req_idx0, req_idx1, upd_valid, upd_idx, upd_taken,
    input  req_ready, resp_valid, resp_pred, upd_ready, init_done
  );

  modport slave (
    input  req_valid, req_idx0, req_idx1, upd_valid, upd_idx, upd_taken,
    output req_ready, resp_valid, resp_pred, upd_ready, init_done
  );
endinterface

// File: rtl/bp_table_arbiter.sv
// Shared table of 2-bit saturating counters: one access per cycle, arbitrated
// between two round-robin lookup ports and a 2-deep training-update FIFO.
module bp_table_arbiter #(
  parameter int ENTRIES = 16,
  parameter int IDX_W   = 4
) (
  input  logic       clk,
  input  logic       rst,
  bp_table_if.slave  bus
);

  typedef enum logic {ST_INIT, ST_RUN} state_e;

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic             taken;
  } upd_t;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] sweep_q, sweep_d;
  logic             last_grant_q, last_grant_d;
  logic [1:0]       count_q, count_d;
  upd_t             fifo_q [2];
  upd_t             fifo_d [2];
  logic [1:0]       resp_valid_q, resp_valid_d;
  logic             resp_pred_q, resp_pred_d;
  logic [1:0]       table_q [ENTRIES];

  logic             run, fifo_full, grant, grant_sel, push, drain;
  logic [1:0]       req_ready_c;
  logic             upd_ready_c;
  logic             wr_en;
  logic [IDX_W-1:0] wr_idx, rd_idx;
  logic [1:0]       wr_val;

  function automatic logic [1:0] train(input logic [1:0] cnt, input logic taken);
    if (taken) return (cnt == 2'b11) ? cnt : cnt + 2'd1;
    else       return (cnt == 2'b00) ? cnt : cnt - 2'd1;
  endfunction

  // Arbitration: a full FIFO forces a drain, otherwise lookups beat the FIFO.
  always_comb begin
    run         = (state_q == ST_RUN);
    fifo_full   = (count_q == 2'd2);
    grant       = run && !fifo_full && (|bus.req_valid);
    grant_sel   = (&bus.req_valid) ? ~last_grant_q : bus.req_valid[1];
    req_ready_c = grant ? (grant_sel ? 2'b10 : 2'b01) : 2'b00;
    upd_ready_c = run && !fifo_full;
    push        = bus.upd_valid && upd_ready_c;
    drain       = run && (fifo_full || (!(|bus.req_valid) && count_q != 2'd0));
    rd_idx      = grant_sel ? bus.req_idx1 : bus.req_idx0;
  end

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d      = state_q;
    sweep_d      = sweep_q;
    wr_en        = 1'b0;
    wr_idx       = fifo_q[0].idx;
    wr_val       = train(table_q[fifo_q[0].idx], fifo_q[0].taken);
    if (!run) begin
      wr_en   = 1'b1;
      wr_idx  = sweep_q;
      wr_val  = 2'b00;
      sweep_d = sweep_q + 1'b1;
      if (sweep_q == IDX_W'(ENTRIES - 1)) state_d = ST_RUN;
    end else if (drain) begin
      wr_en = 1'b1;
    end

    last_grant_d = grant ? grant_sel : last_grant_q;
    resp_valid_d = req_ready_c;
    resp_pred_d  = grant ? table_q[rd_idx][1] : 1'b0;

    fifo_d = fifo_q;
    if (drain) fifo_d[0] = fifo_q[1];
    if (push)  fifo_d[drain ? 1'b0 : count_q[0]] = '{idx: bus.upd_idx, taken: bus.upd_taken};
    count_d = count_q + {1'b0, push} - {1'b0, drain};
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_INIT;
      sweep_q      <= '0;
      last_grant_q <= 1'b1;
      count_q      <= 2'd0;
      resp_valid_q <= 2'b00;
      resp_pred_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      sweep_q      <= sweep_d;
      last_grant_q <= last_grant_d;
      count_q      <= count_d;
      resp_valid_q <= resp_valid_d;
      resp_pred_q  <= resp_pred_d;
    end
  end

  // NOTE: table and FIFO payload carry no reset; the INIT sweep clears the table and count_q gates the FIFO.
  always_ff @(posedge clk) begin
    fifo_q <= fifo_d;
    if (wr_en) table_q[wr_idx] <= wr_val;
  end

  assign bus.req_ready  = req_ready_c;
  assign bus.upd_ready  = upd_ready_c;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_pred  = resp_pred_q;
  assign bus.init_done  = run;

endmodule

// File: tb/tb_bp_table_arbiter.sv
// Directed scoreboard bench for bp_table_arbiter: drivers queue expected
// lookup responses, a negedge monitor pops and compares them.
module tb_bp_table_arbiter;

  typedef struct {
    int   r;
    logic pred;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bp_table_if #(.IDX_W(4)) bus ();

  bp_table_arbiter #(.ENTRIES(16), .IDX_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   n_cmp   = 0;
  int   n_bad   = 0;
  int   tb_last = 1;
  exp_t sb_q[$];
  exp_t mon_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (bus.resp_valid != 2'b00) begin
      if (sb_q.size() == 0) begin
        check("resp_unexpected", 32'(bus.resp_valid), 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        check("resp_port", 32'(bus.resp_valid), 32'(1 << mon_e.r));
        check("resp_pred", 32'(bus.resp_pred), 32'(mon_e.pred));
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge right after rst falls; valids held high to prove gating.
  task automatic init_sweep_check(input string tag);
    bus.req_valid = 2'b11;
    bus.upd_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      #1;
      check({tag, "_init_done_low"}, 32'(bus.init_done), 32'd0);
      check({tag, "_req_ready_init"}, 32'(bus.req_ready), 32'd0);
      check({tag, "_upd_ready_init"}, 32'(bus.upd_ready), 32'd0);
      @(negedge clk);
    end
    bus.req_valid = 2'b00;
    bus.upd_valid = 1'b0;
    #1;
    check({tag, "_init_done_high"}, 32'(bus.init_done), 32'd1);
    tb_last = 1;
    @(negedge clk);
  endtask

  task automatic do_lookup(input int r, input logic [3:0] idx, input logic exp_pred);
    int n = 0;
    bus.req_valid = 2'b00;
    bus.req_valid[r] = 1'b1;
    if (r == 0) bus.req_idx0 = idx;
    else        bus.req_idx1 = idx;
    #1;
    while (!bus.req_ready[r] && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 50) begin
      check("lookup_timeout", 32'(n), 32'd0);
    end else begin
      sb_q.push_back('{r: r, pred: exp_pred});
      tb_last = r;
    end
    @(negedge clk);
    bus.req_valid = 2'b00;
  endtask

  task automatic do_update(input logic [3:0] idx, input logic taken);
    int n = 0;
    bus.upd_valid = 1'b1;
    bus.upd_idx   = idx;
    bus.upd_taken = taken;
    #1;
    while (!bus.upd_ready && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 50) check("update_timeout", 32'(n), 32'd0);
    @(negedge clk);
    bus.upd_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got %0d compared, expected completion", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt, acc, r;
    bus.req_valid = 2'b00;
    bus.req_idx0  = '0;
    bus.req_idx1  = '0;
    bus.upd_valid = 1'b0;
    bus.upd_idx   = '0;
    bus.upd_taken = 1'b0;

    // Reset values, then INIT sweep timing.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", 32'(bus.req_ready), 32'd0);
    check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rst_resp_pred", 32'(bus.resp_pred), 32'd0);
    check("rst_upd_ready", 32'(bus.upd_ready), 32'd0);
    check("rst_init_done", 32'(bus.init_done), 32'd0);
    rst = 1'b0;
    init_sweep_check("boot");

    for (int i = 0; i < 16; i++) do_lookup(i % 2, 4'(i), 1'b0);

    // Saturation on idx 5.
    repeat (4) do_update(4'd5, 1'b1);
    idle(2);
    do_lookup(0, 4'd5, 1'b1);
    repeat (2) do_update(4'd5, 1'b0);
    idle(2);
    do_lookup(0, 4'd5, 1'b0);
    repeat (5) do_update(4'd5, 1'b0);
    do_update(4'd5, 1'b1);
    idle(2);
    do_lookup(0, 4'd5, 1'b0);
    do_update(4'd5, 1'b1);
    idle(2);
    do_lookup(0, 4'd5, 1'b1);

    // Pre-train idx 8, 9, 10 and 3 to 01.
    do_update(4'd8, 1'b1);
    do_update(4'd9, 1'b1);
    do_update(4'd10, 1'b1);
    do_update(4'd3, 1'b1);
    idle(2);

    // Round-robin: idx 5 reads 1, idx 0 reads 0.
    bus.req_idx0  = 4'd5;
    bus.req_idx1  = 4'd0;
    bus.req_valid = 2'b11;
    for (int i = 0; i < 6; i++) begin
      #1;
      r = 1 - tb_last;
      check("rr_req_ready", 32'(bus.req_ready), 32'(1 << r));
      sb_q.push_back('{r: r, pred: (r == 0)});
      tb_last = r;
      @(negedge clk);
    end
    bus.req_valid = 2'b00;
    idle(2);

    // Backpressure: both requesters plus updates held until three updates land.
    bus.req_idx0  = 4'd0;
    bus.req_idx1  = 4'd0;
    bus.req_valid = 2'b11;
    cnt = 0;
    acc = 0;
    bus.upd_valid = 1'b1;
    bus.upd_idx   = 4'd8;
    bus.upd_taken = 1'b1;
    for (int c = 0; c < 12 && acc < 3; c++) begin
      #1;
      if (cnt == 2) begin
        check("bp_req_ready_drain", 32'(bus.req_ready), 32'd0);
        check("bp_upd_ready_full", 32'(bus.upd_ready), 32'd0);
        cnt = 1;
      end else begin
        r = 1 - tb_last;
        check("bp_req_ready", 32'(bus.req_ready), 32'(1 << r));
        check("bp_upd_ready", 32'(bus.upd_ready), 32'd1);
        sb_q.push_back('{r: r, pred: 1'b0});
        tb_last = r;
        cnt++;
        acc++;
      end
      @(negedge clk);
      bus.upd_idx = 4'(8 + acc);
      if (acc == 3) begin
        bus.upd_valid = 1'b0;
        bus.req_valid = 2'b00;
      end
    end
    check("bp_accepted", 32'(acc), 32'd3);
    idle(3);
    do_lookup(0, 4'd8, 1'b1);
    do_lookup(1, 4'd9, 1'b1);
    do_lookup(0, 4'd10, 1'b1);
    idle(3);

    // Stale read: idx 3 at 01, taken update accepted on T, lookup on T+1.
    bus.upd_valid = 1'b1;
    bus.upd_idx   = 4'd3;
    bus.upd_taken = 1'b1;
    #1;
    check("stale_upd_ready", 32'(bus.upd_ready), 32'd1);
    @(negedge clk);
    bus.upd_valid = 1'b0;
    bus.req_idx0  = 4'd3;
    bus.req_valid = 2'b01;
    #1;
    check("stale_req_ready", 32'(bus.req_ready), 32'd1);
    sb_q.push_back('{r: 0, pred: 1'b0});
    tb_last = 0;
    @(negedge clk);
    bus.req_valid = 2'b00;
    @(negedge clk);
    do_lookup(0, 4'd3, 1'b1);
    idle(2);

    // Mid-operation reset with two queued updates and a response in flight.
    bus.upd_valid = 1'b1;
    bus.upd_idx   = 4'd5;
    bus.upd_taken = 1'b1;
    bus.req_idx0  = 4'd5;
    bus.req_valid = 2'b01;
    for (int i = 0; i < 2; i++) begin
      #1;
      check("mid_req_ready", 32'(bus.req_ready), 32'd1);
      check("mid_upd_ready", 32'(bus.upd_ready), 32'd1);
      sb_q.push_back('{r: 0, pred: 1'b1});
      @(negedge clk);
    end
    #1;
    check("mid_fifo_full", 32'(bus.upd_ready), 32'd0);
    rst = 1'b1;
    bus.upd_valid = 1'b0;
    bus.req_valid = 2'b00;
    @(negedge clk);
    check("mid_rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("mid_rst_upd_ready", 32'(bus.upd_ready), 32'd0);
    check("mid_rst_init_done", 32'(bus.init_done), 32'd0);
    rst = 1'b0;
    init_sweep_check("mid");
    do_lookup(0, 4'd5, 1'b0);
    do_lookup(1, 4'd8, 1'b0);
    do_lookup(0, 4'd3, 1'b0);

    idle(4);
    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
